// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and width helpers for the SPI master.
//   spi_state_t   : controller state encoding (IDLE, SETUP, HIGH, LOW, GAP)
//   SPI_BIT_WIDTH : default payload word width
//   div_cnt_w()   : width of the half-period divider counter
//   bit_cnt_w()   : width of the rising-edge bit counter (fits 2*BIT_WIDTH)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BIT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } spi_state_t;

    function automatic int div_cnt_w(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

    function automatic int bit_cnt_w(input int bit_width);
        return $clog2(2 * bit_width + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period tick generator for the SPI master. Restarts its count on the
// accepting edge of a transaction and then raises tick for one cycle out of
// every CLK_DIV, so the first tick lands CLK_DIV cycles after the restart.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   restart : clear the count (transaction accepted this cycle)
//   tick    : one-cycle pulse marking the end of a half-period
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // With CLK_DIV=1 the counter is stuck at 0 and tick is permanently high,
    // which gives an sclk toggle on every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 (CPOL=0, CPHA=0), MSB-first SPI controller with active-low chip
// select. Sends one BIT_WIDTH-bit word per transaction; with the
// SPI_MASTER_READBACK_EN macro defined the frame is 2*BIT_WIDTH bits
// (tx_data followed by zeros) and every miso bit is captured into rx_data.
// Without the macro miso is ignored and rx_data is constant zero.
//   clk, reset : system clock, asynchronous active-high reset
//   start      : request a transaction (sampled only in IDLE)
//   tx_data    : word to send, captured on the accepting edge
//   busy       : transaction or post-transaction gap in progress
//   done       : one-cycle pulse when cs rises
//   rx_data    : last captured miso frame
//   sclk, cs, mosi, miso : SPI bus
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int BIT_WIDTH = SPI_BIT_WIDTH,
    parameter int CLK_DIV   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIT_WIDTH-1:0]   tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [2*BIT_WIDTH-1:0] rx_data,
    output logic                   sclk,
    output logic                   cs,
    output logic                   mosi,
    input  logic                   miso
);

`ifdef SPI_MASTER_READBACK_EN
    localparam int N = 2 * BIT_WIDTH;
`else
    localparam int N = BIT_WIDTH;
`endif
    localparam int BCW = bit_cnt_w(BIT_WIDTH);
    localparam logic [BCW-1:0] N_BITS = BCW'(N);

    spi_state_t state, state_nx;
    logic tick;
    logic accept, rise, fall, finish, gap_end;

    // Holds the bits still to be sent after the one currently on mosi, so
    // tx_sh[N-1] is always the next mosi value; zeros fill in from the bottom.
    logic [N-1:0]   tx_sh;
    logic [BCW-1:0] bit_cnt;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        rise     = 1'b0;
        fall     = 1'b0;
        finish   = 1'b0;
        gap_end  = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = SETUP;
            end
            SETUP: if (tick) begin
                rise     = 1'b1;
                state_nx = HIGH;
            end
            HIGH: if (tick) begin
                fall     = 1'b1;
                state_nx = LOW;
            end
            LOW: if (tick) begin
                if (bit_cnt == N_BITS) begin
                    finish   = 1'b1;
                    state_nx = GAP;
                end else begin
                    rise     = 1'b1;
                    state_nx = HIGH;
                end
            end
            GAP: if (tick) begin
                gap_end  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sh   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
`ifdef SPI_MASTER_READBACK_EN
                tx_sh <= {tx_data[BIT_WIDTH-2:0], {(BIT_WIDTH + 1){1'b0}}};
`else
                tx_sh <= {tx_data[BIT_WIDTH-2:0], 1'b0};
`endif
                bit_cnt <= '0;
                cs      <= 1'b0;
                busy    <= 1'b1;
                mosi    <= tx_data[BIT_WIDTH-1];
            end
            if (rise) begin
                sclk    <= 1'b1;
                bit_cnt <= bit_cnt + BCW'(1);
            end
            if (fall) begin
                sclk  <= 1'b0;
                mosi  <= tx_sh[N-1];
                tx_sh <= tx_sh << 1;
            end
            if (finish) begin
                cs   <= 1'b1;
                mosi <= 1'b0;
            end
            if (gap_end)
                busy <= 1'b0;
        end
    end

`ifdef SPI_MASTER_READBACK_EN
    logic [N-1:0] rx_sh;

    // miso is sampled on the same clock edge that raises sclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            if (rise)
                rx_sh <= {rx_sh[N-2:0], miso};
            if (finish)
                rx_data <= rx_sh;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_data     = '0;
`endif

endmodule

// File: doc/spi_master.md
# spi_master

FPGA-side SPI controller. It is the initiating end of the same mode-0 (CPOL=0, CPHA=0), MSB-first, active-low-CS link that the MCU-facing peripheral implements. From the system clock it generates sclk, cs and mosi, serialises one BIT_WIDTH-bit word per transaction, and can optionally capture a readback word from miso. It sits between on-chip producers (e.g. the note/duration decoder) and an external SPI peripheral, and is also used as the bus driver in loopback benches of the peripheral.

## Interface
- BIT_WIDTH, 16: payload word width.
- CLK_DIV, 4: clk cycles per sclk half-period, ≥1.

- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request a transaction; sampled only while idle.
- tx_data  input  BIT_WIDTH  word to send; captured on the accepting edge.
- busy  output  1  transaction or post-transaction gap in progress.
- done  output  1  one-cycle pulse at transaction end.
- rx_data  output  2*BIT_WIDTH  last captured miso word, MSB first.
- sclk  output  1  serial clock, idles low.
- cs  output  1  chip select, active low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

## Operation
- States: IDLE, SETUP, HIGH, LOW, GAP.
- N = BIT_WIDTH bits, or 2*BIT_WIDTH with readback enabled (see Configuration).
- IDLE, start=1 at edge E0:
  - Load shift register with tx_data.
  - Set cs=0, busy=1, and mosi = tx_data[MSB].
  - Go to SETUP.
- start while busy=1: ignored, not queued.
- SETUP: sclk=0 for CLK_DIV cycles, then sclk←1, go to HIGH.
- HIGH:
  - On entry, sample miso into the receive shift register.
  - After CLK_DIV cycles, sclk←0, go to LOW.
  - On that same edge, mosi advances to the next bit, or to 0 after the last payload bit.
- LOW:
  - After CLK_DIV cycles, if bits remain, sclk←1 and go to HIGH.
  - Otherwise, at the same edge: cs←1, mosi←0, done←1, rx_data←receive register. Go to GAP.
- GAP: cs high for CLK_DIV cycles, then busy←0, go to IDLE.
- Bit counter counts completed rising edges; the transaction ends after exactly N rising edges.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state IDLE.
- Reset mid-transaction aborts immediately and asynchronously. cs deasserts with no done pulse, and rx_data is cleared.

## Timing
- All edges below are relative to E0:
  - cs falls at E0.
  - Rising sclk k (k = 0..N-1) occurs at E0 + CLK_DIV·(2k+1).
  - cs rises and done pulses at E0 + CLK_DIV·(2N+1).
  - busy falls at E0 + CLK_DIV·(2N+2).
- cs low duration: CLK_DIV·(2N+1) cycles.
- Minimum cs high time between transactions: CLK_DIV+1 cycles.
- With start held high, transactions start every CLK_DIV·(2N+2)+1 cycles.
- mosi is stable for ≥CLK_DIV cycles before and after each rising sclk.
- miso is sampled by clk at the rising-sclk edge. The peripheral updates miso on falling sclk, giving ≥CLK_DIV cycles of setup.
- done is high for exactly one cycle. rx_data holds its value until the next done or reset.

## Configuration
- Macro: SPI_MASTER_READBACK_EN.
- Defined:
  - N = 2·BIT_WIDTH.
  - mosi sends tx_data, then BIT_WIDTH zeros.
  - All N miso bits are captured into rx_data.
- Undefined:
  - N = BIT_WIDTH.
  - miso is ignored; rx_data is constant 0 and the receive register is not synthesised.

## Structure
- Package spi_pkg holds:
  - the state enum typedef (spi_state_t);
  - the default BIT_WIDTH constant;
  - width helpers for the divider counter ($clog2(CLK_DIV+1)) and bit counter ($clog2(2·BIT_WIDTH+1)).
- Sub-module spi_clk_div: half-period tick generator. It restarts on transaction accept and emits a one-cycle tick every CLK_DIV cycles. The FSM, shift registers and bit counter remain in spi_master.

## Test plan
- **Basic send.** BIT_WIDTH=16, CLK_DIV=2, readback off, tx_data=0xA5C3, start pulse.
  - mosi sampled on sclk rises yields 0xA5C3.
  - 16 rising edges; cs low 66 cycles.
  - done is one cycle at E0+66; busy falls at E0+68.
- **Readback.** SPI_MASTER_READBACK_EN defined, peripheral model shifts out 0x12345678 (MSB presented before first rise).
  - rx_data=0x12345678 at done.
  - mosi carries 0xBEEF then 16 zeros.
- **Start while busy.** Pulse start at E0+10 with tx_data=0xFFFF.
  - Ignored: mosi still carries the original word, and only one done occurs.
- **Back-to-back.** start held high, CLK_DIV=2, N=16.
  - Second cs fall at E0+69.
  - cs high exactly 3 cycles between transactions.
- **Reset mid-transfer.** Assert reset at E0+20 (between clk edges).
  - cs=1, sclk=0, mosi=0, busy=0, rx_data=0 immediately.
  - No done; a new start after release completes normally.
- **Minimum divider.** CLK_DIV=1, tx_data=0x0001.
  - sclk toggles every cycle, cs low 33 cycles.
  - Last mosi bit is 1; done at E0+33.
